// File: rtl/pdu_writer_pkg.sv
// Types and constants shared by the PDU writer and the packet ring buffer.
package pdu_writer_pkg;

    // Largest packet the ring buffer guarantees room for when not almost_full.
    localparam int RB_THRESHOLD = 64;

    localparam int FLIT_WIDTH = 512;

    // Flit as stored in the PDU BRAM: payload plus packet delimiters.
    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
    } flit_lite_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP,
        WAIT_BASE
    } pdu_writer_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pdu_writer.sv
// Ingress writer: stores each packet contiguously from the ring tail, commits
// it with one update pulse, drops packets on almost_full, truncates oversize.
module pdu_writer
    import pdu_writer_pkg::*;
#(
    parameter int PDU_DEPTH     = 512,
    parameter int PDU_AWIDTH    = $clog2(PDU_DEPTH),
    parameter int MAX_PKT_FLITS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [511:0]          in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  in_valid,
    output logic                  in_ready,
    output flit_lite_t            wr_data,
    output logic [PDU_AWIDTH-1:0] wr_addr,
    output logic                  wr_en,
    input  logic [PDU_AWIDTH-1:0] wr_base_addr,
    input  logic                  wr_base_addr_valid,
    input  logic                  almost_full,
    output logic                  update_valid,
    output logic [PDU_AWIDTH-1:0] update_size,
    output logic [31:0]           drop_cnt,
    output logic [31:0]           trunc_cnt,
    output logic [31:0]           err_cnt
);

    localparam logic [PDU_AWIDTH-1:0] LAST_OFFSET = PDU_AWIDTH'(MAX_PKT_FLITS - 1);
    localparam logic [PDU_AWIDTH-1:0] MAX_SIZE    = PDU_AWIDTH'(MAX_PKT_FLITS);

    pdu_writer_state_t     state_reg;
    logic [PDU_AWIDTH-1:0] base_reg;
    logic [PDU_AWIDTH-1:0] offset_reg;
    // A commit has been issued but the ring has not yet returned the new tail.
    logic                  pending_reg;

    logic                  accept;
    logic [PDU_AWIDTH-1:0] cur_addr;
    logic [PDU_AWIDTH:0]   wide_addr;
    logic                  pending_now;

    assign accept      = in_valid & in_ready;
    assign cur_addr    = base_reg + offset_reg;
    assign wide_addr   = {1'b0, base_reg} + {1'b0, offset_reg};
    assign pending_now = pending_reg & ~wr_base_addr_valid;

    // Packet FSM with all outputs registered; counters saturate inline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            offset_reg   <= '0;
            pending_reg  <= 1'b0;
            in_ready     <= 1'b1;
            wr_data      <= '0;
            wr_addr      <= '0;
            wr_en        <= 1'b0;
            update_valid <= 1'b0;
            update_size  <= '0;
            drop_cnt     <= '0;
            trunc_cnt    <= '0;
            err_cnt      <= '0;
        end else begin
            wr_en        <= 1'b0;
            update_valid <= 1'b0;
            if (wr_base_addr_valid) begin
                pending_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (!in_sop) begin
                            err_cnt <= sat_inc(err_cnt);
                        end else if (almost_full) begin
                            drop_cnt <= sat_inc(drop_cnt);
                            if (!in_eop) begin
                                state_reg <= DROP;
                            end
                        end else begin
                            base_reg <= wr_base_addr;
                            wr_en    <= 1'b1;
                            wr_addr  <= wr_base_addr;
                            wr_data  <= '{data: in_data, sop: in_sop, eop: in_eop};
                            if (in_eop) begin
                                update_valid <= 1'b1;
                                update_size  <= PDU_AWIDTH'(1);
                                pending_reg  <= 1'b1;
                                in_ready     <= 1'b0;
                                state_reg    <= WAIT_BASE;
                            end else begin
                                offset_reg <= PDU_AWIDTH'(1);
                                state_reg  <= WRITE;
                            end
                        end
                    end
                end

                WRITE: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cur_addr;
                        wr_data <= '{data: in_data, sop: in_sop, eop: in_eop};
                        if (in_eop) begin
                            update_valid <= 1'b1;
                            update_size  <= offset_reg + PDU_AWIDTH'(1);
                            pending_reg  <= 1'b1;
                            in_ready     <= 1'b0;
                            state_reg    <= WAIT_BASE;
                        end else if (offset_reg == LAST_OFFSET) begin
                            // Oversize: close the stored packet here and discard the rest.
                            wr_data      <= '{data: in_data, sop: in_sop, eop: 1'b1};
                            update_valid <= 1'b1;
                            update_size  <= MAX_SIZE;
                            pending_reg  <= 1'b1;
                            trunc_cnt    <= sat_inc(trunc_cnt);
                            state_reg    <= DROP;
                        end else begin
                            offset_reg <= offset_reg + PDU_AWIDTH'(1);
                        end
                    end
                end

                DROP: begin
                    if (accept && in_eop) begin
                        if (pending_now) begin
                            in_ready  <= 1'b0;
                            state_reg <= WAIT_BASE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end

                WAIT_BASE: begin
                    if (wr_base_addr_valid) begin
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    in_ready  <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Flag any in-packet address that would run past the end of the BRAM.
    always_comb begin
        if (state_reg == WRITE) begin
            assert (wide_addr < (PDU_AWIDTH+1)'(PDU_DEPTH));
        end
    end

endmodule

// File: tb/tb_pdu_writer.sv
// Directed bench for pdu_writer with a minimal ring-buffer tail model.
module tb_pdu_writer;
    import pdu_writer_pkg::*;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [511:0]  in_data = '0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    flit_lite_t    wr_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic [AW-1:0] wr_base_addr = '0;
    logic          wr_base_addr_valid = 1'b0;
    logic          almost_full = 1'b0;
    logic          update_valid;
    logic [AW-1:0] update_size;
    logic [31:0]   drop_cnt;
    logic [31:0]   trunc_cnt;
    logic [31:0]   err_cnt;

    int total = 0;
    int bad = 0;

    logic [AW-1:0] next_tail = '0;
    logic          uv_last = 1'b0;

    logic [AW-1:0] wq_addr[$];
    bit            wq_sop[$];
    bit            wq_eop[$];
    logic [15:0]   wq_tag[$];
    logic [AW-1:0] cq_size[$];
    bit            cq_eopw[$];

    pdu_writer #(.PDU_DEPTH(512), .PDU_AWIDTH(AW), .MAX_PKT_FLITS(64)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .in_valid(in_valid), .in_ready(in_ready),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
        .wr_base_addr(wr_base_addr), .wr_base_addr_valid(wr_base_addr_valid),
        .almost_full(almost_full),
        .update_valid(update_valid), .update_size(update_size),
        .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wq_addr.delete(); wq_sop.delete(); wq_eop.delete(); wq_tag.delete();
        cq_size.delete(); cq_eopw.delete();
    endtask

    // One clock: sample outputs 1ns after the edge, model the ring tail return.
    task automatic tick();
        @(posedge clk);
        #1;
        wr_base_addr_valid = uv_last;
        if (uv_last) wr_base_addr = next_tail;
        uv_last = update_valid;
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_sop.push_back(wr_data.sop);
            wq_eop.push_back(wr_data.eop);
            wq_tag.push_back(wr_data.data[15:0]);
            $display("write addr=%0d tag=%0d sop=%0b eop=%0b", wr_addr, wr_data.data[15:0], wr_data.sop, wr_data.eop);
        end
        if (update_valid) begin
            cq_size.push_back(update_size);
            cq_eopw.push_back(wr_en && wr_data.eop);
            $display("commit size=%0d", update_size);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int tag, input logic sop, input logic eop);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = 512'(tag);
        in_sop   = sop;
        in_eop   = eop;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check_eq("ready_timeout", 64'(in_ready), 64'd1);
        tick();
    endtask

    task automatic send_pkt(input int n, input int tag0);
        for (int i = 0; i < n; i++) send(tag0 + i, i == 0, i == n - 1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r0, r1, r2;

        // Reset state
        rst = 1'b1;
        #12;
        rst = 1'b0;
        tick();
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_wr_en", 64'(wr_en), 64'd0);
        check_eq("rst_update_valid", 64'(update_valid), 64'd0);
        check_eq("rst_counters", 64'(drop_cnt | trunc_cnt | err_cnt), 64'd0);

        // 3-flit packet at tail 0
        clear_log();
        wr_base_addr = 9'd0; next_tail = 9'd3;
        send(10, 1'b1, 1'b0);
        send(11, 1'b0, 1'b0);
        send(12, 1'b0, 1'b1);
        r0 = in_ready;
        in_valid = 1'b0;
        tick(); r1 = in_ready;
        tick(); r2 = in_ready;
        idle(2);
        check_eq("p1_ready_gap0", 64'(r0), 64'd0);
        check_eq("p1_ready_gap1", 64'(r1), 64'd0);
        check_eq("p1_ready_back", 64'(r2), 64'd1);
        check_eq("p1_nwrites", 64'(wq_addr.size()), 64'd3);
        if (wq_addr.size() == 3) begin
            check_eq("p1_addr0", 64'(wq_addr[0]), 64'd0);
            check_eq("p1_addr2", 64'(wq_addr[2]), 64'd2);
            check_eq("p1_sop0", 64'(wq_sop[0]), 64'd1);
            check_eq("p1_sop1", 64'(wq_sop[1]), 64'd0);
            check_eq("p1_eop1", 64'(wq_eop[1]), 64'd0);
            check_eq("p1_eop2", 64'(wq_eop[2]), 64'd1);
            check_eq("p1_tag1", 64'(wq_tag[1]), 64'd11);
        end
        check_eq("p1_ncommits", 64'(cq_size.size()), 64'd1);
        if (cq_size.size() == 1) begin
            check_eq("p1_size", 64'(cq_size[0]), 64'd3);
            check_eq("p1_commit_with_eop", 64'(cq_eopw[0]), 64'd1);
        end

        // Single sop+eop flit at tail 447, then next packet at returned tail 0
        clear_log();
        wr_base_addr = 9'd447; next_tail = 9'd0;
        send_pkt(1, 20);
        idle(3);
        check_eq("p2_nwrites", 64'(wq_addr.size()), 64'd1);
        if (wq_addr.size() == 1) begin
            check_eq("p2_addr", 64'(wq_addr[0]), 64'd447);
            check_eq("p2_sop_eop", 64'({wq_sop[0], wq_eop[0]}), 64'd3);
        end
        if (cq_size.size() == 1) check_eq("p2_size", 64'(cq_size[0]), 64'd1);
        else check_eq("p2_ncommits", 64'(cq_size.size()), 64'd1);
        clear_log();
        next_tail = 9'd2;
        send_pkt(2, 30);
        idle(3);
        check_eq("p3_nwrites", 64'(wq_addr.size()), 64'd2);
        if (wq_addr.size() == 2) begin
            check_eq("p3_addr0", 64'(wq_addr[0]), 64'd0);
            check_eq("p3_addr1", 64'(wq_addr[1]), 64'd1);
        end
        if (cq_size.size() == 1) check_eq("p3_size", 64'(cq_size[0]), 64'd2);
        else check_eq("p3_ncommits", 64'(cq_size.size()), 64'd1);

        // almost_full at sop drops whole 5-flit packet even if it falls mid-packet
        clear_log();
        almost_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) almost_full = 1'b0;
            send(40 + i, i == 0, i == 4);
        end
        idle(3);
        check_eq("drop_nwrites", 64'(wq_addr.size()), 64'd0);
        check_eq("drop_ncommits", 64'(cq_size.size()), 64'd0);
        check_eq("drop_cnt", 64'(drop_cnt), 64'd1);
        check_eq("drop_ready", 64'(in_ready), 64'd1);

        // 70-flit packet truncated at 64
        clear_log();
        wr_base_addr = 9'd100; next_tail = 9'd164;
        send_pkt(70, 100);
        idle(4);
        check_eq("trunc_nwrites", 64'(wq_addr.size()), 64'd64);
        if (wq_addr.size() == 64) begin
            check_eq("trunc_addr0", 64'(wq_addr[0]), 64'd100);
            check_eq("trunc_addr63", 64'(wq_addr[63]), 64'd163);
            check_eq("trunc_sop0", 64'(wq_sop[0]), 64'd1);
            check_eq("trunc_eop62", 64'(wq_eop[62]), 64'd0);
            check_eq("trunc_eop63", 64'(wq_eop[63]), 64'd1);
            check_eq("trunc_tag63", 64'(wq_tag[63]), 64'd163);
        end
        check_eq("trunc_ncommits", 64'(cq_size.size()), 64'd1);
        if (cq_size.size() == 1) check_eq("trunc_size", 64'(cq_size[0]), 64'd64);
        check_eq("trunc_cnt", 64'(trunc_cnt), 64'd1);
        check_eq("trunc_ready", 64'(in_ready), 64'd1);

        // Flit without sop while idle
        clear_log();
        send(200, 1'b0, 1'b0);
        idle(2);
        check_eq("err_cnt", 64'(err_cnt), 64'd1);
        check_eq("err_nwrites", 64'(wq_addr.size()), 64'd0);

        // Asynchronous reset after 2 flits of a 4-flit packet
        clear_log();
        send(300, 1'b1, 1'b0);
        send(301, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_wr_en", 64'(wr_en), 64'd0);
        check_eq("arst_wr_addr", 64'(wr_addr), 64'd0);
        check_eq("arst_in_ready", 64'(in_ready), 64'd1);
        check_eq("arst_counters", 64'(drop_cnt | trunc_cnt | err_cnt), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("arst_no_commit", 64'(cq_size.size()), 64'd0);
        clear_log();
        next_tail = 9'd168;
        send_pkt(4, 400);
        idle(3);
        check_eq("post_nwrites", 64'(wq_addr.size()), 64'd4);
        if (wq_addr.size() == 4) begin
            check_eq("post_addr0", 64'(wq_addr[0]), 64'd164);
            check_eq("post_addr3", 64'(wq_addr[3]), 64'd167);
        end
        if (cq_size.size() == 1) check_eq("post_size", 64'(cq_size[0]), 64'd4);
        else check_eq("post_ncommits", 64'(cq_size.size()), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdu_writer.md
# pdu_writer

- Ingress stage directly upstream of the packet ring buffer.
- Accepts a flit stream, writes each packet contiguously into the ring buffer's PDU BRAM starting at the buffer's current tail (`wr_base_addr`), then commits the packet with a single `update_valid`/`update_size` pulse.
- Drops whole packets when the buffer reports `almost_full`, truncates oversize packets, and exposes drop/truncate/error counters.

## Interface
Parameters:
- `PDU_DEPTH`, 512: ring buffer depth in flits; power of two.
- `PDU_AWIDTH`, `$clog2(PDU_DEPTH)`: address width.
- `MAX_PKT_FLITS`, 64: maximum flits written per packet; must be ≤ 64 (the ring buffer threshold).

Ports:
- Clock and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `in_data`  in  512  flit payload.
- `in_sop`  in  1  first flit of packet.
- `in_eop`  in  1  last flit of packet.
- `in_valid`  in  1  flit present.
- `in_ready`  out  1  flit accepted when `in_valid & in_ready`.
- `wr_data`  out  flit_lite_t (514)  `{data, sop, eop}` to BRAM.
- `wr_addr`  out  PDU_AWIDTH  BRAM write address.
- `wr_en`  out  1  BRAM write strobe.
- `wr_base_addr`  in  PDU_AWIDTH  current ring tail.
- `wr_base_addr_valid`  in  1  tail updated after a commit.
- `almost_full`  in  1  ring buffer nearly full.
- `update_valid`  out  1  commit pulse.
- `update_size`  out  PDU_AWIDTH  flits in committed packet.
- `drop_cnt`  out  32  packets dropped for `almost_full`.
- `trunc_cnt`  out  32  packets truncated.
- `err_cnt`  out  32  flits received outside a packet.

## Operation
States:
- IDLE
  - `in_ready`=1.
  - Accepted flit with `in_sop`=1 and `almost_full`=0: latch `base`=`wr_base_addr`, write the flit at `base` (offset 0).
    - If `in_eop`=1 as well, commit with size 1 and go to WAIT_BASE; otherwise set offset to 1 and go to WRITE.
  - Accepted flit with `in_sop`=1 and `almost_full`=1: `drop_cnt`++. Go to DROP unless `in_eop`=1, in which case stay in IDLE.
  - Accepted flit with `in_sop`=0: discard it, `err_cnt`++.
- WRITE
  - `in_ready`=1.
  - Each accepted flit is written at `base+offset`, then offset++.
  - On `in_eop`: commit with `update_size`=offset+1, go to WAIT_BASE.
  - If offset = `MAX_PKT_FLITS`-1 and `in_eop`=0: write the flit with eop forced to 1, commit with size `MAX_PKT_FLITS`, `trunc_cnt`++, go to DROP.
  - A `in_sop` seen mid-packet is treated as a data flit and stored as received.
- DROP
  - `in_ready`=1.
  - Discard flits until and including `in_eop`.
  - Exit to WAIT_BASE if a commit is still pending its `wr_base_addr_valid`; otherwise exit to IDLE.
- WAIT_BASE
  - `in_ready`=0 until `wr_base_addr_valid`=1 is sampled, then go to IDLE.
  - This guarantees the next packet latches the advanced tail.

Rules:
- `almost_full` is sampled only on an accepted sop flit. A deassertion or assertion mid-packet has no effect.
- Addresses: `base` is always < `PDU_DEPTH`-64 and offset is < `MAX_PKT_FLITS`, so `base+offset` never wraps.
  - Computed at PDU_AWIDTH bits.
  - A simulation assertion flags `base+offset` ≥ `PDU_DEPTH`.
- Counters saturate at 2^32-1.
- Reset mid-packet: the partial packet is never committed, so the tail is unchanged. The BRAM contents written so far are don't-care.

## Timing
- All outputs are registered. Reset value is 0 for every output except `in_ready`, which is 1 (state IDLE).
- Write latency: an accepted flit at edge E produces `wr_en`/`wr_addr`/`wr_data` valid for one cycle after E.
- Commit: `update_valid` is a one-cycle pulse in the same cycle as the eop `wr_en`.
- Next packet after a commit:
  - The ring buffer returns `wr_base_addr_valid` one cycle after `update_valid`.
  - `in_ready` is low for 2 cycles after the eop accept, then high.
  - Minimum packet-to-packet gap is therefore 2 idle cycles.
- Throughput: 1 flit/cycle inside a packet.

## Structure
- Shared package:
  - `flit_lite_t`, already in the common struct file.
  - Add the `pdu_writer_state_t` enum {IDLE, WRITE, DROP, WAIT_BASE}.
  - Add the `RB_THRESHOLD` = 64 constant, also used by the ring buffer.
- No sub-module: the three counters are plain saturating registers inline.

## Test plan
- Reset, then one 3-flit packet at tail 0:
  - Writes at addresses 0, 1, 2 with sop at 0 and eop at 2.
  - `update_valid` with size 3 coincident with the addr-2 write.
  - `in_ready` low for exactly 2 cycles afterwards.
- Single sop+eop flit with tail=447: write at 447, size 1, then the next packet's base equals the returned tail 0.
- `almost_full`=1 at sop of a 5-flit packet: no `wr_en`, no `update_valid`, `drop_cnt`=1. `almost_full` falling mid-packet does not resume writing.
- 70-flit packet with `MAX_PKT_FLITS`=64:
  - Writes at base..base+63, with eop set at base+63.
  - size 64, `trunc_cnt`=1.
  - Flits 65–70 discarded.
- Flit without sop in IDLE: discarded, `err_cnt`=1, no write.
- `rst` asserted after 2 flits of a 4-flit packet: all outputs return to reset values asynchronously and no `update_valid` occurs. The next packet latches the unchanged `wr_base_addr`.
